// File: rtl/weasel_pkg.sv
// Shared types and helpers for the dispatch stage and its entry queue.
package weasel_pkg;

  // Bits needed to hold an occupancy value in 0..size.
  function automatic int unsigned size_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

  typedef enum logic {
    DISP_EMPTY,
    DISP_HOLD
  } dispatch_state_e;

  // Default per-lane entry payload.
  typedef logic [3:0] entry_t;

endpackage

// File: rtl/dispatch_stage_if.sv
// Decode-to-dispatch bundle handshake: per-lane valid/data plus a single ready.
interface dispatch_stage_if
  import weasel_pkg::*;
#(
  parameter int unsigned Producers = 2,
  parameter type         T         = entry_t
);

  logic [Producers-1:0] valid;
  T     [Producers-1:0] data;
  logic                 ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/dispatch_compact.sv
// Packs the set lanes of a bundle toward lane 0, preserving lane order, and counts them.
module dispatch_compact #(
  parameter int unsigned Producers = 2,
  parameter type         T         = logic [3:0],
  localparam int unsigned CntW     = $clog2(Producers + 1)
) (
  input  logic [Producers-1:0] valid,
  input  T     [Producers-1:0] data,
  output T     [Producers-1:0] packed_data,
  output logic [CntW-1:0]      cnt
);

  int unsigned idx;

  // Lane k lands in slot idx, where idx counts set lanes below k; unused slots read zero.
  always_comb begin
    packed_data = '0;
    idx         = 0;
    for (int unsigned k = 0; k < Producers; k++) begin
      if (valid[k]) begin
        for (int unsigned j = 0; j < Producers; j++) begin
          if (idx == j) begin
            packed_data[j] = data[k];
          end
        end
        idx = idx + 1;
      end
    end
    cnt = CntW'(idx);
  end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: registers a compacted decode bundle and pushes it into the entry
// queue only when the whole bundle fits in the queue's free space.
// Optional build macro DISPATCH_STALL_COUNT_EN adds a saturating stall-cycle counter.
module dispatch_stage
  import weasel_pkg::*;
#(
  parameter int unsigned Size      = 4,
  parameter type         T         = entry_t,
  parameter int unsigned Producers = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  dispatch_stage_if.slave             up,
  input  logic                        i_flush,
  input  logic [size_width(Size)-1:0] i_size,
  output logic [Producers-1:0]        o_push,
  output T     [Producers-1:0]        o_data
`ifdef DISPATCH_STALL_COUNT_EN
  ,
  output logic [15:0]                 o_stall_cnt
`endif
);

  localparam int unsigned SizeW = size_width(Size);
  localparam int unsigned CntW  = $clog2(Producers + 1);

  dispatch_state_e      state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  T     [Producers-1:0] data_q, data_d;

  T     [Producers-1:0] cmp_data;
  logic [CntW-1:0]      cmp_cnt;

  logic                 hold_valid;
  logic [SizeW:0]       free;
  logic                 fits;
  logic                 accept;

  dispatch_compact #(
    .Producers (Producers),
    .T         (T)
  ) u_compact (
    .valid       (up.valid),
    .data        (up.data),
    .packed_data (cmp_data),
    .cnt         (cmp_cnt)
  );

  // Room check against the reported occupancy; pops this cycle are deliberately not credited.
  always_comb begin
    hold_valid = (state_q == DISP_HOLD);
    free       = (SizeW + 1)'(Size) - {1'b0, i_size};
    fits       = hold_valid && (32'(cnt_q) <= 32'(free));
    up.ready   = !i_rst_n || !hold_valid || fits;
    accept     = up.ready && (|up.valid) && !i_flush;
  end

  // Queue-facing outputs: contiguous push from lane 0, data shown even while stalled.
  always_comb begin
    o_push = '0;
    for (int unsigned k = 0; k < Producers; k++) begin
      o_push[k] = i_rst_n && fits && !i_flush && (32'(k) < 32'(cnt_q));
    end
    o_data = (i_rst_n && hold_valid) ? data_q : '0;
  end

  // Next-state: load on accept, drain to empty once pushed, flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      DISP_EMPTY: begin
        if (accept) begin
          state_d = DISP_HOLD;
          cnt_d   = cmp_cnt;
          data_d  = cmp_data;
        end
      end
      DISP_HOLD: begin
        if (accept) begin
          cnt_d  = cmp_cnt;
          data_d = cmp_data;
        end else if (fits) begin
          state_d = DISP_EMPTY;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = DISP_EMPTY;
        cnt_d   = '0;
      end
    endcase
    if (i_flush) begin
      state_d = DISP_EMPTY;
      cnt_d   = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= DISP_EMPTY;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef DISPATCH_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Counts cycles a held bundle waits for room; saturates, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (hold_valid && !fits && !i_flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

  // Queue occupancy beyond capacity means the queue and this stage disagree on Size.
  size_legal_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    32'(i_size) <= Size);

endmodule
